// File: rtl/binary_to_gray.sv
// binary_to_gray: registered binary-to-Gray encoder with an independent
// Gray-to-binary decoder, one-cycle latency and a single valid qualifier.
// Optional macro BIN2GRAY_CHECK_EN adds a sticky round-trip error flag that
// decodes the registered Gray output and compares it with the binary input
// that produced it. Without the macro, err is tied to 0.
module binary_to_gray #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] binary_in,
    input  logic [WIDTH-1:0] gray_in,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] binary_out,
    output logic             out_valid,
    output logic             err
);

    logic [WIDTH-1:0] gray_d;
    logic [WIDTH-1:0] bin_d;
    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] bin_q;
    logic             valid_q;

    // XOR chain from MSB downwards; each binary bit depends on all Gray bits above it
    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b            = '0;
        b[WIDTH-1]   = g[WIDTH-1];
        for (int unsigned i = 1; i < WIDTH; i++) begin
            b[WIDTH-1-i] = b[WIDTH-i] ^ g[WIDTH-1-i];
        end
        return b;
    endfunction

    // Combinational encode and decode of the current inputs
    always_comb begin
        gray_d            = '0;
        gray_d[WIDTH-1]   = binary_in[WIDTH-1];
        for (int unsigned i = 0; i + 1 < WIDTH; i++) begin
            gray_d[i] = binary_in[i+1] ^ binary_in[i];
        end
        bin_d = gray2bin(gray_in);
    end

    // Output register: capture on valid, hold data otherwise, reset wins
    always_ff @(posedge clk) begin
        if (rst) begin
            gray_q  <= '0;
            bin_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                gray_q <= gray_d;
                bin_q  <= bin_d;
            end
        end
    end

    assign gray_out   = gray_q;
    assign binary_out = bin_q;
    assign out_valid  = valid_q;

`ifdef BIN2GRAY_CHECK_EN
    logic [WIDTH-1:0] bin_copy_q;
    logic             err_q;
    logic             mismatch;

    // Round-trip comparison of the registered Gray code against its source
    always_comb begin
        mismatch = valid_q && (gray2bin(gray_q) != bin_copy_q);
    end

    // Source copy tracks the output register; err is sticky until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_copy_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (in_valid) begin
                bin_copy_q <= binary_in;
            end
            if (mismatch) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_binary_to_gray.sv
// Self-checking bench for binary_to_gray: a 4-bit instance checked every cycle
// against an arithmetic reference model, plus an 8-bit instance for wide
// boundary codes and a long random run watching err.
module tb_binary_to_gray;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] binary_in;
    logic [3:0] gray_in;
    logic [3:0] gray_out;
    logic [3:0] binary_out;
    logic       out_valid;
    logic       err;

    logic       rst8;
    logic       in_valid8;
    logic [7:0] binary_in8;
    logic [7:0] gray_in8;
    logic [7:0] gray_out8;
    logic [7:0] binary_out8;
    logic       out_valid8;
    logic       err8;

    int checks = 0;
    int errors = 0;

    // Reference model state for the 4-bit instance
    logic [3:0] exp_gray = '0;
    logic [3:0] exp_bin  = '0;
    logic       exp_vld  = 1'b0;
    logic       model_on = 1'b0;

    always #5 clk = ~clk;

    binary_to_gray #(.WIDTH(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .binary_in  (binary_in),
        .gray_in    (gray_in),
        .gray_out   (gray_out),
        .binary_out (binary_out),
        .out_valid  (out_valid),
        .err        (err)
    );

    binary_to_gray #(.WIDTH(8)) dut8 (
        .clk        (clk),
        .rst        (rst8),
        .in_valid   (in_valid8),
        .binary_in  (binary_in8),
        .gray_in    (gray_in8),
        .gray_out   (gray_out8),
        .binary_out (binary_out8),
        .out_valid  (out_valid8),
        .err        (err8)
    );

    function automatic logic [31:0] m_b2g(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Binary bit i is the parity of all Gray bits at position i and above
    function automatic logic [31:0] m_g2b(input logic [31:0] g);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) r[i] = ^(g >> i);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model advances on each rising edge from the inputs the bench applied
    always @(posedge clk) begin
        if (rst) begin
            exp_gray = '0;
            exp_bin  = '0;
            exp_vld  = 1'b0;
            model_on = 1'b1;
        end else if (in_valid) begin
            exp_gray = 4'(m_b2g(32'(binary_in)));
            exp_bin  = 4'(m_g2b(32'(gray_in)));
            exp_vld  = 1'b1;
        end else begin
            exp_vld  = 1'b0;
        end
    end

    // Every-cycle compare of the 4-bit instance against the model
    always @(negedge clk) begin
        if (model_on) begin
            check("cyc_gray", 32'(gray_out), 32'(exp_gray));
            check("cyc_bin", 32'(binary_out), 32'(exp_bin));
            check("cyc_vld", 32'(out_valid), 32'(exp_vld));
            check("cyc_err", 32'(err), 32'd0);
            check("cyc_err8", 32'(err8), 32'd0);
        end
    end

    logic [3:0] gtab [16];
    logic [3:0] prev_g;
    logic [3:0] hist_prev;
    logic [7:0] v8;

    initial begin
        gtab = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};

        // Pin the model with hand-derived codes
        for (int i = 0; i < 16; i++) begin
            check("model_b2g", m_b2g(32'(i)), 32'(gtab[i]));
            check("model_g2b", m_g2b(32'(gtab[i])), 32'(i));
        end

        // Reset for two cycles with valid data present
        rst = 1'b1; in_valid = 1'b1; binary_in = 4'b1010; gray_in = 4'b1010;
        rst8 = 1'b1; in_valid8 = 1'b0; binary_in8 = '0; gray_in8 = '0;
        for (int k = 0; k < 2; k++) begin
            step();
            check("rst_gray", 32'(gray_out), 32'd0);
            check("rst_bin", 32'(binary_out), 32'd0);
            check("rst_vld", 32'(out_valid), 32'd0);
            check("rst_err", 32'(err), 32'd0);
        end
        rst = 1'b0; rst8 = 1'b0;

        // Encode and decode sweep, including the wrap back to 0
        for (int i = 0; i <= 16; i++) begin
            binary_in = 4'(i); gray_in = gtab[i % 16]; in_valid = 1'b1;
            step();
            check("sweep_gray", 32'(gray_out), 32'(gtab[i % 16]));
            check("sweep_bin", 32'(binary_out), 32'(i % 16));
            check("sweep_vld", 32'(out_valid), 32'd1);
            if (i > 0) check("sweep_1bit", 32'($countones(gray_out ^ prev_g)), 32'd1);
            prev_g = gray_out;
        end

        // Valid gaps: one valid then two idle cycles with changing data
        binary_in = 4'd5; gray_in = 4'd0; in_valid = 1'b1;
        step();
        check("gap_vld_hi", 32'(out_valid), 32'd1);
        in_valid = 1'b0; binary_in = 4'd9; gray_in = 4'd9;
        for (int k = 0; k < 2; k++) begin
            step();
            check("gap_hold", 32'(gray_out), 32'b0111);
            check("gap_bin_hold", 32'(binary_out), 32'd0);
            check("gap_vld_lo", 32'(out_valid), 32'd0);
        end

        // Idle X-free data must not disturb held outputs
        binary_in = 4'hF; gray_in = 4'hF;
        step();
        check("idle_hold", 32'(gray_out), 32'b0111);

        // Reset mid-stream at value 7, then resume with 8
        for (int i = 0; i <= 8; i++) begin
            binary_in = 4'(i); gray_in = gtab[i]; in_valid = 1'b1;
            rst = (i == 7);
            step();
            if (i == 7) begin
                check("mid_rst_gray", 32'(gray_out), 32'd0);
                check("mid_rst_vld", 32'(out_valid), 32'd0);
            end
        end
        rst = 1'b0;
        check("post_rst_gray", 32'(gray_out), 32'b1100);
        check("post_rst_vld", 32'(out_valid), 32'd1);

        // Loopback: Gray output fed back recovers binary input two edges later
        binary_in = 4'($urandom); gray_in = gray_out; in_valid = 1'b1;
        step();
        hist_prev = binary_in;
        for (int k = 0; k < 40; k++) begin
            gray_in   = gray_out;
            binary_in = 4'($urandom);
            step();
            check("loopback", 32'(binary_out), 32'(hist_prev));
            hist_prev = binary_in;
        end

        // Random traffic with occasional reset and idle cycles
        for (int k = 0; k < 300; k++) begin
            binary_in = 4'($urandom);
            gray_in   = 4'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 29) == 0);
            step();
        end
        rst = 1'b0; in_valid = 1'b0;

        // 8-bit instance: boundary codes
        in_valid8 = 1'b1;
        binary_in8 = 8'hFF; gray_in8 = 8'h80;
        step();
        check("w8_ff", 32'(gray_out8), 32'h80);
        check("w8_dec_80", 32'(binary_out8), 32'hFF);
        binary_in8 = 8'h80; gray_in8 = 8'hC0;
        step();
        check("w8_80", 32'(gray_out8), 32'hC0);
        check("w8_dec_c0", 32'(binary_out8), 32'h80);
        binary_in8 = 8'h00; gray_in8 = 8'h00;
        step();
        check("w8_00", 32'(gray_out8), 32'h00);
        check("w8_vld", 32'(out_valid8), 32'd1);

        // 8-bit random run
        for (int k = 0; k < 1000; k++) begin
            v8         = 8'($urandom);
            binary_in8 = v8;
            gray_in8   = 8'(m_b2g(32'(v8)));
            step();
            check("w8_rand_gray", 32'(gray_out8), m_b2g(32'(v8)));
            check("w8_rand_bin", 32'(binary_out8), 32'(v8));
        end
        check("w8_err_final", 32'(err8), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
